// File: rtl/kernel_nios2_oci_jtag_sequencer.sv
// JTAG-to-OCI debug RAM sequencer: turns JTAG strobes into single RAM reads/writes.
// Optional waitrequest timeout is enabled by defining KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN.
module kernel_nios2_oci_jtag_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mon;
    logic              r_ready;
    logic              r_read;
    logic              r_write;

    logic              w_busy;
    logic              w_accept;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addrInc;
    logic              w_unused;

    assign w_busy    = r_read | r_write;
    assign w_accept  = (r_state == IDLE) &
                       (take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a);
    assign w_addrInc = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_unused  = ^{jdo[37:36], jdo[2:0]};

`ifdef KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

    logic [15:0] r_waitCnt;
    logic        r_error;

    // Counter holds the number of stalled cycles already seen; the stall that would reach TIMEOUT aborts.
    assign w_timeout = w_busy & mem_waitrequest & (r_waitCnt == (LP_TIMEOUT - 16'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waitCnt <= '0;
            r_error   <= 1'b0;
        end else if (w_accept) begin
            r_waitCnt <= '0;
            r_error   <= 1'b0;
        end else if (w_timeout) begin
            r_error   <= 1'b1;
        end else if (w_busy && mem_waitrequest) begin
            r_waitCnt <= r_waitCnt + 16'd1;
        end
    end

    assign monitor_error = r_error;
`else
    assign w_timeout     = 1'b0;
    assign monitor_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mon   <= '0;
            r_ready <= 1'b1;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (take_action_ocimem_b) begin
                        r_wdata <= jdo[34:3];
                        r_write <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= WRITE;
                    end else if (take_action_ocimem_a) begin
                        r_addr <= jdo[ADDR_W+25:26];
                        if (jdo[35]) begin
                            r_read  <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= READ;
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        r_read  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= READ;
                    end
                end
                READ, WRITE: begin
                    // Strobes are ignored here; only the RAM handshake or the timeout ends a command.
                    if (!mem_waitrequest) begin
                        if (r_state == READ) begin
                            r_mon <= mem_readdata;
                        end
                        r_addr  <= w_addrInc;
                        r_ready <= 1'b1;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_ready <= 1'b1;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_address   = r_addr;
    assign mem_read      = r_read;
    assign mem_write     = r_write;
    assign mem_writedata = r_wdata;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;

endmodule

// File: tb/tb_kernel_nios2_oci_jtag_sequencer.sv
// Self-checking bench for kernel_nios2_oci_jtag_sequencer with a RAM responder and a
// transaction-level model; timeout scenario is built when KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN is defined.
module tb_kernel_nios2_oci_jtag_sequencer;

`ifdef KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif
    localparam int OP_LOADNR = 0;
    localparam int OP_LOADRD = 1;
    localparam int OP_WRITE  = 2;
    localparam int OP_READ   = 3;
    localparam int BUDGET    = 3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int checks = 0;
    int errors = 0;

    // RAM responder state
    logic [31:0] ram [256];
    int          waitCfg = 0;
    bit          stuck = 1'b0;
    bit          active = 1'b0;
    int          remaining = 0;
    logic [7:0]  cmdAddr;
    logic [31:0] cmdData;
    int          rdCycles = 0;
    int          wrCycles = 0;
    logic [7:0]  lastWrAddr = '0;
    logic [31:0] lastWrData = '0;

    // Reference model
    logic [31:0] expMem [256];
    logic [7:0]  mAddr = '0;
    logic [31:0] mMon = '0;

    kernel_nios2_oci_jtag_sequencer #(.ADDR_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // RAM device: stalls for waitCfg cycles (or forever when stuck), then serves the command
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (!active) begin
                active    = 1'b1;
                remaining = waitCfg;
                cmdAddr   = mem_address;
                cmdData   = mem_writedata;
            end
            if (mem_read)  rdCycles++;
            if (mem_write) wrCycles++;
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("[TB] FAIL bus_exclusive: read=%0b write=%0b, required not both", mem_read, mem_write);
            end
            checks++;
            if (mem_address !== cmdAddr || (mem_write && mem_writedata !== cmdData)) begin
                errors++;
                $display("[TB] FAIL bus_stable: addr=%h data=%h, required addr=%h data=%h",
                         mem_address, mem_writedata, cmdAddr, cmdData);
            end
            if (stuck || remaining > 0) begin
                mem_waitrequest = 1'b1;
                if (remaining > 0) remaining--;
            end else begin
                mem_waitrequest = 1'b0;
                if (mem_read) begin
                    mem_readdata = ram[mem_address];
                end else begin
                    ram[mem_address] = mem_writedata;
                    lastWrAddr = mem_address;
                    lastWrData = mem_writedata;
                end
            end
        end else begin
            active          = 1'b0;
            mem_waitrequest = 1'b0;
        end
    end

    task automatic issue_cmd(input int op, input logic [7:0] a, input logic [31:0] d,
                             input int waits, input bit stick,
                             output int cycles, output logic readyAtAccept);
        @(negedge clk);
        waitCfg  = waits;
        stuck    = stick;
        rdCycles = 0;
        wrCycles = 0;
        jdo      = '0;
        case (op)
            OP_LOADNR: begin jdo[33:26] = a; take_action_ocimem_a = 1'b1; end
            OP_LOADRD: begin jdo[33:26] = a; jdo[35] = 1'b1; take_action_ocimem_a = 1'b1; end
            OP_WRITE:  begin jdo[34:3] = d; take_action_ocimem_b = 1'b1; end
            default:   take_no_action_ocimem_a = 1'b1;
        endcase
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        readyAtAccept = monitor_ready;
        cycles = 0;
        while (!monitor_ready && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        if (!monitor_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_done: monitor_ready=%0b after %0d cycles, required 1", monitor_ready, cycles);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, monitor_ready, monitor_error} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL reset_flags: rd/wr/rdy/err=%b, required 0010",
                     {mem_read, mem_write, monitor_ready, monitor_error});
        end
        checks++;
        if (mem_address !== 8'h00 || mem_writedata !== 32'h0 || MonDReg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: addr=%h wdata=%h mon=%h, required 0", mem_address, mem_writedata, MonDReg);
        end
        #2 reset_n = 1'b1;
        mAddr = '0;
        mMon  = '0;
    endtask

    task automatic test_read_wait();
        int cycles;
        logic rdy0;
        ram[8'h10]    = 32'hDEADBEEF;
        expMem[8'h10] = 32'hDEADBEEF;
        issue_cmd(OP_LOADRD, 8'h10, 32'h0, 3, 1'b0, cycles, rdy0);
        mMon  = 32'hDEADBEEF;
        mAddr = 8'h11;
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_accept_ready: got %0b, required 0", rdy0);
        end
        checks++;
        if (rdCycles != 4 || cycles != 4) begin
            errors++;
            $display("[TB] FAIL read_wait_cycles: read=%0d done=%0d, required 4 4", rdCycles, cycles);
        end
        checks++;
        if (MonDReg !== mMon || mem_address !== mAddr || monitor_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_result: mon=%h addr=%h rdy=%0b, required %h %h 1",
                     MonDReg, mem_address, monitor_ready, mMon, mAddr);
        end
    endtask

    task automatic test_write_wrap();
        int cycles;
        logic rdy0;
        issue_cmd(OP_LOADNR, 8'hFF, 32'h0, 0, 1'b0, cycles, rdy0);
        mAddr = 8'hFF;
        checks++;
        if (rdy0 !== 1'b1 || mem_address !== mAddr || rdCycles != 0) begin
            errors++;
            $display("[TB] FAIL load_only: rdy=%0b addr=%h reads=%0d, required 1 ff 0", rdy0, mem_address, rdCycles);
        end
        issue_cmd(OP_WRITE, 8'h00, 32'h12345678, 0, 1'b0, cycles, rdy0);
        expMem[8'hFF] = 32'h12345678;
        mAddr = 8'h00;
        checks++;
        if (wrCycles != 1 || cycles != 1 || lastWrAddr !== 8'hFF || lastWrData !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL write_bus: cycles=%0d done=%0d at %h data %h, required 1 1 ff 12345678",
                     wrCycles, cycles, lastWrAddr, lastWrData);
        end
        checks++;
        if (mem_address !== mAddr || monitor_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_wrap: addr=%h rdy=%0b, required 00 1", mem_address, monitor_ready);
        end
    endtask

    task automatic test_priority_busy();
        int n;
        logic [31:0] d;
        d = $urandom;
        @(negedge clk);
        waitCfg  = 2;
        stuck    = 1'b0;
        rdCycles = 0;
        wrCycles = 0;
        jdo      = '0;
        jdo[34:3] = d;
        take_action_ocimem_b    = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || monitor_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_accept: wr=%0b rd=%0b rdy=%0b, required 1 0 0", mem_write, mem_read, monitor_ready);
        end
        @(negedge clk);
        jdo[33:26] = mAddr + 8'h40;
        take_no_action_ocimem_a = 1'b1;
        take_action_ocimem_a    = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_a    = 1'b0;
        n = 0;
        while (!monitor_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        expMem[mAddr] = d;
        checks++;
        if (lastWrAddr !== mAddr || lastWrData !== d || wrCycles != 3 || rdCycles != 0) begin
            errors++;
            $display("[TB] FAIL prio_bus: wr %h@%h cycles=%0d reads=%0d, required %h@%h 3 0",
                     lastWrData, lastWrAddr, wrCycles, rdCycles, d, mAddr);
        end
        mAddr = mAddr + 8'd1;
        checks++;
        if (mem_address !== mAddr || monitor_ready !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_addr: addr=%h rdy=%0b rd=%0b, required %h 1 0",
                     mem_address, monitor_ready, mem_read, mAddr);
        end
    endtask

    task automatic test_random();
        int cycles, op, w, expCycles;
        logic rdy0;
        logic [7:0] a;
        logic [31:0] d;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(3, 0);
            w  = $urandom_range(3, 0);
            a  = 8'($urandom);
            d  = $urandom;
            issue_cmd(op, a, d, w, 1'b0, cycles, rdy0);
            expCycles = w + 1;
            case (op)
                OP_LOADNR: begin mAddr = a; expCycles = 0; end
                OP_LOADRD: begin mMon = expMem[a]; mAddr = a + 8'd1; end
                OP_WRITE: begin
                    checks++;
                    if (lastWrAddr !== mAddr || lastWrData !== d) begin
                        errors++;
                        $display("[TB] FAIL rand_write[%0d]: %h@%h, required %h@%h", i, lastWrData, lastWrAddr, d, mAddr);
                    end
                    expMem[mAddr] = d;
                    mAddr = mAddr + 8'd1;
                end
                default: begin mMon = expMem[mAddr]; mAddr = mAddr + 8'd1; end
            endcase
            checks++;
            if (cycles != expCycles || rdCycles + wrCycles != expCycles || rdy0 !== (expCycles == 0)) begin
                errors++;
                $display("[TB] FAIL rand_timing[%0d]: done=%0d bus=%0d rdy0=%0b, required %0d",
                         i, cycles, rdCycles + wrCycles, rdy0, expCycles);
            end
            checks++;
            if (mem_address !== mAddr || MonDReg !== mMon || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_state[%0d]: addr=%h mon=%h rdy=%0b err=%0b, required %h %h 1 0",
                         i, mem_address, MonDReg, monitor_ready, monitor_error, mAddr, mMon);
            end
        end
    endtask

`ifdef KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        logic rdy0;
        issue_cmd(OP_READ, 8'h00, 32'h0, 0, 1'b1, cycles, rdy0);
        checks++;
        if (rdCycles != 4 || cycles != 4 || mem_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_len: reads=%0d done=%0d rd=%0b, required 4 4 0", rdCycles, cycles, mem_read);
        end
        checks++;
        if (monitor_error !== 1'b1 || monitor_ready !== 1'b1 || mem_address !== mAddr || MonDReg !== mMon) begin
            errors++;
            $display("[TB] FAIL timeout_state: err=%0b rdy=%0b addr=%h mon=%h, required 1 1 %h %h",
                     monitor_error, monitor_ready, mem_address, MonDReg, mAddr, mMon);
        end
        stuck = 1'b0;
        issue_cmd(OP_LOADNR, mAddr, 32'h0, 0, 1'b0, cycles, rdy0);
        checks++;
        if (monitor_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: err=%0b, required 0", monitor_error);
        end
    endtask
`else
    task automatic test_long_stall();
        int cycles;
        logic rdy0;
        issue_cmd(OP_READ, 8'h00, 32'h0, 1000, 1'b0, cycles, rdy0);
        mMon  = expMem[mAddr];
        mAddr = mAddr + 8'd1;
        checks++;
        if (cycles != 1001 || rdCycles != 1001 || monitor_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_stall: done=%0d reads=%0d err=%0b, required 1001 1001 0",
                     cycles, rdCycles, monitor_error);
        end
        checks++;
        if (MonDReg !== mMon || mem_address !== mAddr) begin
            errors++;
            $display("[TB] FAIL long_stall_data: mon=%h addr=%h, required %h %h", MonDReg, mem_address, mMon, mAddr);
        end
    endtask
`endif

    task automatic test_reset_midcmd();
        @(negedge clk);
        stuck    = 1'b1;
        jdo      = '0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, monitor_ready, monitor_error} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL reset_mid_flags: rd/wr/rdy/err=%b, required 0010",
                     {mem_read, mem_write, monitor_ready, monitor_error});
        end
        checks++;
        if (mem_address !== 8'h00 || mem_writedata !== 32'h0 || MonDReg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_regs: addr=%h wdata=%h mon=%h, required 0", mem_address, mem_writedata, MonDReg);
        end
        stuck = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        mAddr = '0;
        mMon  = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = $urandom;
            expMem[i] = ram[i];
        end
        $display("[TB] starting, TIMEOUT=%0d", TB_TIMEOUT);
        test_reset();
        test_read_wait();
        test_write_wrap();
        test_priority_busy();
        test_random();
`ifdef KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        test_reset_midcmd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_nios2_oci_jtag_sequencer.md
KERNEL_NIOS2_OCI_JTAG_SEQUENCER -- requirements
Module: kernel_nios2_oci_jtag_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the word-address width of the OCI debug RAM port.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of waitrequest cycles before abort (range 1..2^16-1).
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  system clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port jdo  in  38  JTAG shift data, already synchronised to clk.
REQ-007 SHALL have port take_action_ocimem_a  in  1  one-cycle strobe for an address load, with optional read.
REQ-008 SHALL have port take_action_ocimem_b  in  1  one-cycle strobe for a write at the current address.
REQ-009 SHALL have port take_no_action_ocimem_a  in  1  one-cycle strobe for a read at the current address.
REQ-010 SHALL have port mem_address  out  ADDR_W  RAM word address.
REQ-011 SHALL have port mem_read / mem_write  out  1 each  RAM commands, never both high.
REQ-012 SHALL have port mem_writedata  out  32  RAM write data.
REQ-013 SHALL have port mem_readdata  in  32  RAM read data, valid when mem_read is high and mem_waitrequest is low.
REQ-014 SHALL have port mem_waitrequest  in  1  RAM stall.
REQ-015 SHALL have port MonDReg  out  32  last read data returned to the JTAG side.
REQ-016 SHALL have port monitor_ready  out  1  set when the last accepted command completes.
REQ-017 SHALL have port monitor_error  out  1  set when the last accepted command timed out.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE.
REQ-019 In IDLE, SHALL accept strobes with priority take_action_ocimem_b > take_action_ocimem_a > take_no_action_ocimem_a; lower-priority strobes in the same cycle are dropped.
REQ-020 On take_action_ocimem_a, SHALL load the address register from jdo[ADDR_W+25:26].
 - If jdo[35]=1: SHALL also enter READ at the new address in the next cycle.
 - If jdo[35]=0: SHALL stay in IDLE and set monitor_ready=1 in the next cycle.
REQ-021 On take_action_ocimem_b, SHALL latch jdo[34:3] into mem_writedata and enter WRITE.
REQ-022 On take_no_action_ocimem_a, SHALL enter READ.
REQ-023 Command acceptance SHALL clear monitor_ready and monitor_error in the next cycle.
REQ-024 In READ/WRITE, SHALL hold mem_read/mem_write high, with stable address and data, until mem_waitrequest=0.
REQ-025 Read completion SHALL capture mem_readdata into MonDReg, set monitor_ready, increment the address, and return to IDLE, all on the same clock edge.
REQ-026 Write completion SHALL set monitor_ready, increment the address, and return to IDLE on the same edge.
 - Minimum command-to-done latency is 2 cycles with zero wait.
REQ-027 Address increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-028 Strobes arriving in READ or WRITE SHALL be ignored, with no state or address change.
REQ-029 A take_action_ocimem_a address load without read SHALL not increment the address.

Reset
REQ-030 reset_n low SHALL force the following, asynchronously:
 - state=IDLE;
 - address, mem_writedata, MonDReg = 0;
 - mem_read, mem_write, monitor_error = 0;
 - monitor_ready = 1.
REQ-031 Reset asserted mid-command SHALL drop mem_read/mem_write immediately, with no completion flag.

Configuration
REQ-032 The macro KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN SHALL control the timeout logic.
REQ-033 With KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN defined:
 - a 16-bit counter SHALL clear on entry to READ/WRITE and count each cycle with mem_waitrequest=1;
 - reaching TIMEOUT SHALL deassert the command, set monitor_error=1 and monitor_ready=1, leave the address and MonDReg unchanged, and return to IDLE.
REQ-034 Without KERNEL_NIOS2_OCI_SEQ_TIMEOUT_EN:
 - the counter SHALL be absent;
 - the block SHALL wait indefinitely;
 - monitor_error SHALL be constant 0.

Verification
REQ-035 The bench SHALL cover: take_action_ocimem_a with jdo[35]=1, address 0x10, RAM returns 0xDEADBEEF after 3 wait cycles -> mem_read high for 4 cycles, then MonDReg=0xDEADBEEF, monitor_ready=1, address=0x11.
REQ-036 The bench SHALL cover: take_action_ocimem_b with data 0x12345678 at address 0xFF, zero wait -> one mem_write cycle at 0xFF, then address=0x00 (wrap), monitor_ready=1.
REQ-037 The bench SHALL cover: take_action_ocimem_b and take_no_action_ocimem_a in the same cycle, followed by take_no_action_ocimem_a while busy -> only the write executes, and the address advances by 1.
REQ-038 The bench SHALL cover, with the timeout macro on and TIMEOUT=4: mem_waitrequest stuck high -> command drops after 4 wait cycles, monitor_error=1, monitor_ready=1, address unchanged.
REQ-039 The bench SHALL cover: reset_n pulsed low during a stalled read -> mem_read=0 asynchronously, and all outputs at their REQ-030 reset values.
REQ-040 The bench SHALL cover, with the timeout macro off: a 1000-cycle stall, then release -> read completes normally and monitor_error stays 0.
